// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (I-cache fill, D-cache fill/writeback) arbiter in
// front of a single-ported main memory. D normally wins a tie. After
// STARVE_MAX consecutive D grants with I waiting, the next tie goes to I.
// Each transfer walks IDLE -> *_XFER -> ACK -> IDLE. All outputs come straight
// from registers.

module mem_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int LINE_W     = 64,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              i_ack,
    output logic              d_ack,
    output logic [LINE_W-1:0] rd_data,
    output logic              m_re,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_rdy,
    output logic              busy
);

    // Starvation counter width: at least 2 bits, wide enough to hold STARVE_MAX.
    localparam int CNT_RAW = $clog2(STARVE_MAX + 1);
    localparam int CNT_W   = (CNT_RAW < 2) ? 2 : CNT_RAW;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_XFER = 2'd1,
        D_XFER = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_owner;      // 0 = I, 1 = D
    logic              r_op;         // 0 = read, 1 = write
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_rd_data;
    logic              r_m_re;
    logic              r_m_we;
    logic              r_i_ack;
    logic              r_d_ack;
    logic              r_busy;

    logic              w_d_req;
    logic              w_starved;
    logic              w_grant_i;
    logic              w_grant_d;
    logic [CNT_W-1:0]  w_starve_nxt;

    // Tie-break: D wins unless I has already waited through STARVE_MAX D grants.
    assign w_d_req   = d_re | d_we;
    assign w_starved = (r_starve_cnt == STARVE_LIM);
    assign w_grant_i = i_re & (~w_d_req | w_starved);
    assign w_grant_d = w_d_req & ~w_grant_i;

    // Next starvation count: clear on an I grant, count D grants that made I wait, saturate.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (w_grant_i) begin
            w_starve_nxt = CNT_ZERO;
        end else if (w_grant_d && i_re && (r_starve_cnt != STARVE_LIM)) begin
            w_starve_nxt = r_starve_cnt + CNT_ONE;
        end else begin
            w_starve_nxt = r_starve_cnt;
        end
    end

    // Arbitration FSM: grants from IDLE, holds strobes until m_rdy, then a one-cycle ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_starve_cnt <= CNT_ZERO;
            r_owner      <= 1'b0;
            r_op         <= 1'b0;
            r_addr       <= {ADDR_W{1'b0}};
            r_wdata      <= {LINE_W{1'b0}};
            r_rd_data    <= {LINE_W{1'b0}};
            r_m_re       <= 1'b0;
            r_m_we       <= 1'b0;
            r_i_ack      <= 1'b0;
            r_d_ack      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_i_ack      <= 1'b0;
                    r_d_ack      <= 1'b0;
                    r_starve_cnt <= w_starve_nxt;
                    if (w_grant_i) begin
                        r_state <= I_XFER;
                        r_owner <= 1'b0;
                        r_op    <= 1'b0;
                        r_addr  <= i_addr;
                        r_m_re  <= 1'b1;
                        r_m_we  <= 1'b0;
                        r_busy  <= 1'b1;
                    end else if (w_grant_d) begin
                        // A writeback wins over a fill when both are raised together.
                        r_state <= D_XFER;
                        r_owner <= 1'b1;
                        r_op    <= d_we;
                        r_addr  <= d_addr;
                        r_wdata <= d_wdata;
                        r_m_re  <= ~d_we;
                        r_m_we  <= d_we;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_m_re  <= 1'b0;
                        r_m_we  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                I_XFER, D_XFER: begin
                    // Requester inputs are ignored here; address, data and strobe stay latched.
                    if (m_rdy) begin
                        r_state   <= ACK;
                        r_rd_data <= m_rdata;
                        r_m_re    <= 1'b0;
                        r_m_we    <= 1'b0;
                        r_i_ack   <= ~r_owner;
                        r_d_ack   <= r_owner;
                    end else begin
                        r_state <= r_state;
                        r_m_re  <= r_m_re;
                        r_m_we  <= r_m_we;
                    end
                end
                ACK: begin
                    // m_rdy is ignored; always return to IDLE so new requests get a fresh decision.
                    r_state <= IDLE;
                    r_i_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_m_re  <= 1'b0;
                    r_m_we  <= 1'b0;
                    r_i_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign i_ack   = r_i_ack;
    assign d_ack   = r_d_ack;
    assign rd_data = r_rd_data;
    assign m_re    = r_m_re;
    assign m_we    = r_m_we;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign busy    = r_busy;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, the line-address width in main memory.
REQ-002 SHALL have parameter LINE_W, default 64, the cache-line data width.
REQ-003 SHALL have parameter STARVE_MAX, default 3, the number of consecutive D grants allowed while I waits.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have ports i_re (input, 1, I-cache fill request) and i_addr (input, ADDR_W, I fill line address).
REQ-007 SHALL have ports d_re (input, 1, D fill request), d_we (input, 1, D writeback request), d_addr (input, ADDR_W, D line address) and d_wdata (input, LINE_W, D writeback line).
REQ-008 SHALL have ports i_ack and d_ack (output, 1 each, one-cycle completion pulses) and rd_data (output, LINE_W, fill data, valid while an ack is high).
REQ-009 SHALL have ports m_re and m_we (output, 1 each, main-memory read/write strobes), m_addr (output, ADDR_W), m_wdata (output, LINE_W), m_rdata (input, LINE_W) and m_rdy (input, 1, memory done, held one cycle).
REQ-010 SHALL have port busy (output, 1), high whenever the state is not IDLE.

Function
REQ-011 SHALL implement the states IDLE, I_XFER, D_XFER and ACK.
REQ-012 In IDLE with no request, the state SHALL stay IDLE and m_re, m_we, i_ack and d_ack SHALL all be 0.
REQ-013 In IDLE with exactly one requester active, that requester SHALL be granted: I_XFER for i_re, D_XFER for d_re or d_we.
REQ-014 In IDLE with both active, D SHALL be granted, unless starve_cnt == STARVE_MAX, in which case I SHALL be granted.
REQ-015 starve_cnt (2+ bits) SHALL increment when D is granted while i_re is high, and SHALL clear on any I grant; it SHALL saturate at STARVE_MAX.
REQ-016 On grant, the arbiter SHALL register the owner, the address, the op (d_we has priority over d_re if both are set) and wdata.
REQ-017 The registered values SHALL drive m_addr and m_wdata, and SHALL NOT change until the transfer completes.
REQ-018 In I_XFER, m_re SHALL be 1; in D_XFER, exactly one of m_re or m_we SHALL be 1, according to the latched op.
REQ-019 Strobes SHALL be held continuously until m_rdy; requester inputs SHALL be ignored during a transfer.
REQ-020 On m_rdy, the arbiter SHALL capture m_rdata into rd_data, go to ACK and drop the strobes in the same edge.
REQ-021 In ACK, exactly one cycle of i_ack or d_ack SHALL be asserted, matching the owner, and the state SHALL return to IDLE.
REQ-022 rd_data SHALL hold its value after ACK until the next capture.
REQ-023 For a D writeback, d_ack SHALL still pulse; rd_data content is then don't-care.
REQ-024 Minimum request-to-ack latency SHALL be 3 cycles (grant edge, m_rdy edge, ACK cycle), given m_rdy arrives in the first strobe cycle.
REQ-025 A requester SHALL hold its request until its ack; it SHALL deassert in the cycle after ack, or a new transfer will be granted.
REQ-026 A request asserted in the ACK cycle SHALL be considered only from IDLE, so there are no back-to-back grants without an IDLE cycle.
REQ-027 An m_rdy arriving while in IDLE or ACK SHALL be ignored.

Reset
REQ-028 While rst is high at a clock edge, the next state SHALL be IDLE, starve_cnt 0, owner and op 0, m_addr 0, m_wdata 0 and rd_data 0.
REQ-029 While rst is high, m_re, m_we, i_ack, d_ack and busy SHALL all be 0.
REQ-030 Reset mid-transfer SHALL abort the transfer without producing an ack; the memory is responsible for ignoring the dropped strobe.

Verification
REQ-031 I-only fill: i_re=1, i_addr=0x0123, m_rdy one cycle after m_re rises, m_rdata=0xDEAD_BEEF_0000_0001 -> m_re=1 with m_addr=0x0123; then i_ack for 1 cycle with rd_data=0xDEAD_BEEF_0000_0001; d_ack stays 0.
REQ-032 Simultaneous requests: i_re=1 and d_re=1 in the same IDLE cycle -> D is granted first (m_addr=d_addr); after d_ack and D deasserting, I is granted next.
REQ-033 Starvation: i_re held with d_re re-raised every IDLE -> exactly 3 D grants, then the 4th grant goes to I, and starve_cnt returns to 0.
REQ-034 Writeback: d_we=1, d_addr=0x3FFF, d_wdata=0x0123_4567_89AB_CDEF -> m_we=1 with m_wdata=0x0123_4567_89AB_CDEF held stable for a 5-cycle m_rdy delay; then a single d_ack; m_re stays 0 throughout.
REQ-035 Reset during D_XFER: rst=1 for 1 cycle -> m_we drops next cycle, no d_ack, busy=0, and a fresh i_re afterward is granted normally.
REQ-036 Spurious m_rdy asserted in IDLE -> no ack and no state change.
